// File: rtl/truth_table_checker_if.sv
// truth_table_checker_if: start/result bus between the checker and the gate under test.
interface truth_table_checker_if #(
    parameter int N_INPUTS = 2
);
    logic                     start;
    logic [N_INPUTS-1:0]      dut_in;
    logic                     dut_out;
    logic                     busy;
    logic                     done;
    logic                     pass;
    logic [2**N_INPUTS-1:0]   captured;
    logic [N_INPUTS:0]        err_count;
    logic [N_INPUTS-1:0]      fail_index;

    modport master (
        output start, dut_out,
        input  dut_in, busy, done, pass, captured, err_count, fail_index
    );

    modport slave (
        input  start, dut_out,
        output dut_in, busy, done, pass, captured, err_count, fail_index
    );
endinterface

// File: rtl/truth_table_checker.sv
// truth_table_checker: sweeps every input vector of a small combinational gate,
// captures its truth table and compares it with EXPECTED.
module truth_table_checker #(
    parameter int                   N_INPUTS      = 2,
    parameter int                   SETTLE_CYCLES = 4,
    parameter logic [2**N_INPUTS-1:0] EXPECTED    = 4'b1000
) (
    input logic                  clk,
    input logic                  rst,
    truth_table_checker_if.slave bus
);
    localparam int NV = 2**N_INPUTS;
    localparam int CW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    state_t              state, state_nx;
    logic [N_INPUTS-1:0] idx;
    logic [CW-1:0]       cnt;
    logic                first_fail;
    logic                accept, settled, last, mismatch;

    assign accept   = bus.start && (state == IDLE || state == DONE);
    assign settled  = cnt == CW'(SETTLE_CYCLES - 1);
    assign last     = idx == N_INPUTS'(NV - 1);
    assign mismatch = bus.dut_out != EXPECTED[idx];

    always_ff @(posedge clk)
        state <= rst ? IDLE : state_nx;

    always_comb begin
        state_nx = state;
        if (accept)
            state_nx = SETTLE;
        else if (state == SETTLE)
            state_nx = settled ? SAMPLE : SETTLE;
        else if (state == SAMPLE)
            state_nx = last ? DONE : SETTLE;
    end

    // cnt may wrap on the SETTLE->SAMPLE edge; it is reloaded before the next use
    always_ff @(posedge clk) begin
        if (rst) begin
            idx            <= '0;
            cnt            <= '0;
            first_fail     <= 1'b0;
            bus.dut_in     <= '0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.pass       <= 1'b0;
            bus.captured   <= '0;
            bus.err_count  <= '0;
            bus.fail_index <= '0;
        end else if (accept) begin
            idx            <= '0;
            cnt            <= '0;
            first_fail     <= 1'b0;
            bus.dut_in     <= '0;
            bus.busy       <= 1'b1;
            bus.done       <= 1'b0;
            bus.pass       <= 1'b0;
            bus.captured   <= '0;
            bus.err_count  <= '0;
            bus.fail_index <= '0;
        end else if (state == SETTLE) begin
            cnt <= cnt + 1'b1;
        end else if (state == SAMPLE) begin
            bus.captured[idx] <= bus.dut_out;
            if (mismatch) begin
                bus.err_count <= bus.err_count + 1'b1;
                if (!first_fail) begin
                    bus.fail_index <= idx;
                    first_fail     <= 1'b1;
                end
            end
            if (last) begin
                bus.busy <= 1'b0;
                bus.done <= 1'b1;
                bus.pass <= bus.err_count == '0 && !mismatch;
            end else begin
                idx        <= idx + 1'b1;
                bus.dut_in <= idx + 1'b1;
                cnt        <= '0;
            end
        end
    end
endmodule
